arb4_rr_ctrl: RTL and testbench
===============================

# arb4_rr_ctrl

Four-requester round-robin arbiter that shares the team's 2-to-4 decoder-selected resource between four clients. It picks one requester at a time, drives the 2-bit select that feeds the decoder, and outputs the matching one-hot grant. It holds the grant until the owner releases it or a hold timeout expires. It sits between the client request lines and the decoder's select inputs.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced release; 0 disables the timeout.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request lines, bit i = client i, level-sensitive.
- `done` input 1: owner release strobe, sampled only in GRANT.
- `sel` output 2: index of current owner; drives decoder select (`sel[1]` = a, `sel[0]` = b).
- `grant` output 4: one-hot grant, equal to the 2-to-4 decode of `sel` when busy, else 4'b0000.
- `busy` output 1: high while a grant is active.
- `timeout` output 1: one-cycle pulse when a grant is force-released by the hold counter.

## Operation
- Reset values:
  - `grant`=0, `sel`=0, `busy`=0, `timeout`=0.
  - Internal state=IDLE, hold counter=0.
  - Last-owner pointer=3, so client 0 has first priority.
- IDLE state:
  - If `req` is nonzero, choose the first set bit scanning upward, modulo 4, from last-owner+1.
  - Load `sel` with that index, set `grant`/`busy`, load the pointer with the index, set the hold counter to 1, and go to GRANT.
  - If `req` is 0, stay in IDLE; `sel` holds its last value.
- GRANT state, release conditions in priority order:
  1. `done`=1.
  2. `req[sel]`=0 (owner withdrew).
  3. `MAX_HOLD`≠0 and counter==`MAX_HOLD`.
- On any release: clear `grant`/`busy` and go to IDLE. Pulse `timeout` only on condition 3, when 1 and 2 are both false.
- Otherwise the counter increments and saturates at `MAX_HOLD`.
- Counter width is $clog2(MAX_HOLD+1), minimum 1 bit.
- The pointer changes only when a grant is issued. A forced-off owner is therefore lowest priority next round.
- Requests from non-owners during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- `grant` is never more than one-hot. `grant` and `busy` are always consistent.

## Timing
- Grant latency: `req` seen at edge N in IDLE gives `grant`/`sel`/`busy` valid after edge N, i.e. one cycle.
- Release: a condition seen at edge M gives `grant`=0 after edge M.
- IDLE always lasts at least one cycle between grants. The earliest next grant is after edge M+1, so back-to-back ownership is 1 dead cycle.
- With `done` held high, a single client re-granted continuously sees grant alternate 1 cycle on, 1 cycle off.
- Timeout: the owner holds `grant` for exactly `MAX_HOLD` cycles. `timeout` is high in the cycle after the last grant cycle, coincident with the first IDLE cycle.
- `done` asserted in IDLE has no effect.
- `rst` overrides everything on the same edge, including mid-grant: all outputs return to reset values on the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `req`=4'b0001, `done`=0 → after 1 cycle `grant`=4'b0001, `sel`=0, `busy`=1. `done` pulse → `grant`=0 next cycle.
- `req`=4'b1111 held, `done` pulsed on every grant cycle → grant order 0001, 0010, 0100, 1000, 0001, separated by one idle cycle each.
- `MAX_HOLD`=4, `req`=4'b0100 held, `done`=0 → `grant`=4'b0100 for exactly 4 cycles, then 0. `timeout`=1 for one cycle. Re-grant of 4'b0100 occurs one cycle later.
- Owner 1 granted, `req`=4'b0011 → 4'b0001, then `req[1]` dropped → release next cycle with `timeout`=0. Next grant goes to client 0.
- Client 2 granted mid-hold, `rst` asserted one cycle → `grant`=0, `sel`=0, `busy`=0, `timeout`=0. With `req`=4'b1111 after reset, the first grant is 4'b0001.
- `req`=4'b1000, `done`=1 and counter==`MAX_HOLD` on the same edge → release with `timeout`=0.

Source files
------------

// File: rtl/arb4_rr_ctrl_if.sv
// Client-side request/release lines and arbiter-side select/grant status.
// master = client/bench side, slave = arbiter side.
interface arb4_rr_ctrl_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/arb4_rr_ctrl.sv
// Four-client round-robin arbiter driving a 2-to-4 decoder select with a one-hot grant.
// Grant one cycle after a request is seen in IDLE; release one cycle after done/withdraw/timeout.
module arb4_rr_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  arb4_rr_ctrl_if.slave bus
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  state_t        w_state_nxt;
  logic [1:0]    w_sel_nxt;
  logic [1:0]    w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_timeout_nxt;

  logic [1:0]    w_pick;
  logic          w_any_req;
  logic          w_owner_req;
  logic          w_hold_hit;
  logic          w_cnt_room;
  logic          w_busy;

  assign w_any_req   = |bus.req;
  assign w_owner_req = bus.req[r_sel];
  assign w_hold_hit  = (MAX_HOLD != 0) && (r_cnt == HOLD_LIM);
  assign w_cnt_room  = (r_cnt < HOLD_LIM);

  // Scan downward so the closest set bit after the pointer wins; offset 4 wraps to the pointer itself.
  always_comb begin
    w_pick = r_ptr + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[r_ptr + 2'(k)]) begin
        w_pick = r_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_pick;
          w_ptr_nxt   = w_pick;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_GRANT: begin
        // Owner release outranks the hold limit, so a coincident done never reports a timeout.
        if (bus.done || !w_owner_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_hold_hit) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else if (w_cnt_room) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd3;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign w_busy      = (r_state == S_GRANT);
  assign bus.busy    = w_busy;
  assign bus.sel     = r_sel;
  assign bus.grant   = w_busy ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.timeout = r_timeout;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.grant));
  a_grant_busy:   assert property (@(posedge clk) disable iff (rst) (bus.grant != 4'b0000) == bus.busy);

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed vector table plus randomized run against a behavioural arbiter model.
module tb_arb4_rr_ctrl;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb4_rr_ctrl_if bus();

  arb4_rr_ctrl #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  int m_busy, m_owner, m_last, m_held, m_to;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic d,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.s = s; v.b = b; v.t = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 3; m_held = 0; m_to = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
    bit found;
    int cand;
    if (r) begin
      model_reset();
    end else if (m_busy == 0) begin
      m_to  = 0;
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        cand = (m_last + k) % 4;
        if (!found && rq[cand]) begin
          found   = 1;
          m_owner = cand;
          m_last  = cand;
          m_held  = 1;
          m_busy  = 1;
        end
      end
    end else begin
      if (d || !rq[m_owner]) begin
        m_busy = 0; m_to = 0;
      end else if (m_held == MAXH) begin
        m_busy = 0; m_to = 1;
      end else begin
        m_held++; m_to = 0;
      end
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic       dn, rr;
    logic [3:0] eg;

    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;

    //          rst  req      done  grant    sel   busy  tmo
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0)); // reset
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0)); // single grant
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0)); // done release
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0)); // reset, rotation
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0)); // done ignored in IDLE
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0)); // hold timeout
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 2'd2, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0)); // re-grant
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0)); // owner withdraw
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 2'd1, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0)); // reset mid-grant
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0)); // done at hold limit
    tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd3, 0, 0)); // idle keeps sel
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd3, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0)); // forced-off owner loses next round
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0000, 2'd1, 0, 1));
    tbl.push_back(mk(0, 4'b0110, 0, 4'b0100, 2'd2, 1, 0));

    foreach (tbl[i]) begin
      rst      = tbl[i].rst;
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      tick();
      chk($sformatf("vec%0d.grant", i),   32'(bus.grant),   32'(tbl[i].g));
      chk($sformatf("vec%0d.sel", i),     32'(bus.sel),     32'(tbl[i].s));
      chk($sformatf("vec%0d.busy", i),    32'(bus.busy),    32'(tbl[i].b));
      chk($sformatf("vec%0d.timeout", i), 32'(bus.timeout), 32'(tbl[i].t));
    end

    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    tick();
    model_reset();
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      dn = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 99) == 0);
      rst      = rr;
      bus.req  = rq;
      bus.done = dn;
      tick();
      model_step(rr, rq, dn);
      eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk($sformatf("rnd%0d.grant", i),   32'(bus.grant),   32'(eg));
      chk($sformatf("rnd%0d.sel", i),     32'(bus.sel),     32'(m_owner));
      chk($sformatf("rnd%0d.busy", i),    32'(bus.busy),    32'(m_busy));
      chk($sformatf("rnd%0d.timeout", i), 32'(bus.timeout), 32'(m_to));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
